// File: rtl/fc_argmax_scorer.sv
// Serial argmax / loss scorer for the fully_connected score stream.
// Produces per-sample class prediction plus per-batch and running accuracy statistics.
module fc_argmax_scorer #(
    parameter int DATA_W      = 16,
    parameter int NUM_CLASSES = 10,
    parameter int CLASS_W     = 4,
    parameter int BATCH_SIZE  = 32,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_stats,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [NUM_CLASSES-1:0] in_label,
    output logic                   out_valid,
    output logic [CLASS_W-1:0]     pred_class,
    output logic                   pred_correct,
    output logic                   label_err,
    output logic                   batch_done,
    output logic [31:0]            batch_loss,
    output logic [CNT_W-1:0]       batch_correct,
    output logic [31:0]            total_samples,
    output logic [31:0]            total_correct,
    output logic [1:0]             dbg_state
);

    localparam int BCNT_W = $clog2(BATCH_SIZE + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, RESULT = 2'd2} state_t;

    // Handshake: an element transfers on a rising edge where in_valid && in_ready;
    // in_ready drops only in the RESULT cycle and while clear_stats is high.
    state_t                   state_q, state_d;
    logic [CLASS_W-1:0]       cnt_q;
    logic [NUM_CLASSES-1:0]   label_q;
    logic [DATA_W-1:0]        best_q;
    logic [CLASS_W-1:0]       best_idx_q;
    logic [31:0]              loss_q;
    logic [CLASS_W-1:0]       pred_class_q;
    logic                     pred_correct_q, label_err_q, bdone_q;
    logic [BCNT_W-1:0]        batch_cnt_q;
    logic [31:0]              acc_loss_q, batch_loss_q, tot_s_q, tot_c_q;
    logic [CNT_W-1:0]         acc_corr_q, batch_correct_q;

    logic                     accept, first, last, finish, upd, hit, label_nz, correct_d, batch_end;
    logic [CLASS_W-1:0]       k, true_idx, best_idx_d;
    logic [NUM_CLASSES-1:0]   cur_label;
    logic [DATA_W-1:0]        best_d;
    logic [31:0]              term, loss_d, acc_loss_sat;
    logic [32:0]              sum33;
    logic [CNT_W-1:0]         acc_corr_nxt;

    always_comb begin
        in_ready  = (state_q != RESULT) && !clear_stats;
        accept    = in_valid && in_ready;
        first     = (state_q == IDLE);
        k         = first ? '0 : cnt_q;
        cur_label = first ? in_label : label_q;
        label_nz  = |cur_label;
        true_idx  = '0;
        // Lowest set bit wins, so multi-hot labels resolve deterministically.
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            if (cur_label[i]) true_idx = CLASS_W'(i);
        end
        last         = (k == CLASS_W'(NUM_CLASSES - 1));
        finish       = accept && last;
        upd          = first || (in_data > best_q);
        best_d       = upd ? in_data : best_q;
        best_idx_d   = upd ? k : best_idx_q;
        hit          = label_nz && (k == true_idx);
        term         = 32'h0000_FFFF - 32'(in_data);
        loss_d       = hit ? term : (first ? 32'd0 : loss_q);
        correct_d    = label_nz && (best_idx_d == true_idx);
        sum33        = {1'b0, acc_loss_q} + {1'b0, loss_d};
        acc_loss_sat = sum33[32] ? 32'hFFFF_FFFF : sum33[31:0];
        acc_corr_nxt = acc_corr_q + CNT_W'(correct_d);
        batch_end    = (batch_cnt_q == BCNT_W'(BATCH_SIZE - 1));
        out_valid    = (state_q == RESULT) && !clear_stats;
        batch_done   = out_valid && bdone_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = last ? RESULT : ACCUM;
            ACCUM:   if (finish) state_d = RESULT;
            RESULT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_stats) state_d = IDLE;
    end

    // Sample statistics are committed on the last element's edge so they are
    // already visible in the RESULT cycle alongside out_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            label_q         <= '0;
            best_q          <= '0;
            best_idx_q      <= '0;
            loss_q          <= '0;
            pred_class_q    <= '0;
            pred_correct_q  <= 1'b0;
            label_err_q     <= 1'b0;
            bdone_q         <= 1'b0;
            batch_cnt_q     <= '0;
            acc_loss_q      <= '0;
            acc_corr_q      <= '0;
            batch_loss_q    <= '0;
            batch_correct_q <= '0;
            tot_s_q         <= '0;
            tot_c_q         <= '0;
        end else begin
            state_q <= state_d;
            if (clear_stats) begin
                cnt_q           <= '0;
                bdone_q         <= 1'b0;
                batch_cnt_q     <= '0;
                acc_loss_q      <= '0;
                acc_corr_q      <= '0;
                batch_loss_q    <= '0;
                batch_correct_q <= '0;
                tot_s_q         <= '0;
                tot_c_q         <= '0;
            end else if (accept) begin
                cnt_q      <= k + CLASS_W'(1);
                best_q     <= best_d;
                best_idx_q <= best_idx_d;
                loss_q     <= loss_d;
                if (first) label_q <= in_label;
                if (finish) begin
                    pred_class_q   <= best_idx_d;
                    pred_correct_q <= correct_d;
                    label_err_q    <= !label_nz;
                    tot_s_q        <= tot_s_q + 32'd1;
                    tot_c_q        <= tot_c_q + 32'(correct_d);
                    bdone_q        <= batch_end;
                    if (batch_end) begin
                        batch_loss_q    <= acc_loss_sat;
                        batch_correct_q <= acc_corr_nxt;
                        acc_loss_q      <= '0;
                        acc_corr_q      <= '0;
                        batch_cnt_q     <= '0;
                    end else begin
                        acc_loss_q  <= acc_loss_sat;
                        acc_corr_q  <= acc_corr_nxt;
                        batch_cnt_q <= batch_cnt_q + BCNT_W'(1);
                    end
                end
            end
        end
    end

    assign pred_class    = pred_class_q;
    assign pred_correct  = pred_correct_q;
    assign label_err     = label_err_q;
    assign batch_loss    = batch_loss_q;
    assign batch_correct = batch_correct_q;
    assign total_samples = tot_s_q;
    assign total_correct = tot_c_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fc_argmax_scorer.sv
// Self-checking bench for fc_argmax_scorer: randomized samples against a
// queue-based accuracy model, plus directed reset / clear / batch scenarios.
module tb_fc_argmax_scorer;

    localparam int NC = 10;

    logic        clk = 1'b0;
    logic        reset, clear_stats, in_valid, in_ready;
    logic [15:0] in_data;
    logic [9:0]  in_label;
    logic        out_valid, pred_correct, label_err, batch_done;
    logic [3:0]  pred_class;
    logic [31:0] batch_loss, total_samples, total_correct;
    logic [15:0] batch_correct;
    logic [1:0]  dbg_state;

    fc_argmax_scorer dut (
        .clk(clk), .reset(reset), .clear_stats(clear_stats),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_label(in_label),
        .out_valid(out_valid), .pred_class(pred_class), .pred_correct(pred_correct),
        .label_err(label_err), .batch_done(batch_done), .batch_loss(batch_loss),
        .batch_correct(batch_correct), .total_samples(total_samples),
        .total_correct(total_correct), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] pc;
        logic       pcor;
        logic       lerr;
        logic       bd;
    } r1_t;

    typedef struct packed {
        logic [31:0] bl;
        logic [15:0] bc;
        logic [31:0] ts;
        logic [31:0] tc;
    } r2_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    logic [31:0] m_ts, m_tc, m_bl;
    logic [15:0] m_bc;
    int          m_bcorr;
    r1_t         last_e1;

    // Stimulus and observations
    logic [15:0] sc[NC];
    logic [9:0]  lb;
    r1_t         e1, o1;
    r2_t         e2, o2;
    bit          seen, rdy_res, ov_after;
    int          stalls, lat;

    task automatic model_reset();
        exp_q.delete();
        m_ts = 0; m_tc = 0; m_bl = 0; m_bc = 0; m_bcorr = 0;
        last_e1 = '0;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_ts = 0; m_tc = 0; m_bl = 0; m_bc = 0; m_bcorr = 0;
    endtask

    task automatic model_sample();
        int     pred, tru;
        bit     err, cor;
        longint sum;
        pred = 0;
        for (int i = 1; i < NC; i++) if (sc[i] > sc[pred]) pred = i;
        tru = 0;
        for (int i = NC - 1; i >= 0; i--) if (lb[i]) tru = i;
        err = (lb == 0);
        cor = !err && (pred == tru);
        exp_q.push_back(err ? 32'd0 : 32'(16'hFFFF - sc[tru]));
        m_ts += 1;
        m_tc += 32'(cor);
        m_bcorr += int'(cor);
        e1.pc = 4'(pred); e1.pcor = cor; e1.lerr = err; e1.bd = 1'b0;
        if (exp_q.size() == 32) begin
            sum = 0;
            foreach (exp_q[i]) sum += longint'(exp_q[i]);
            m_bl = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
            m_bc = 16'(m_bcorr);
            exp_q.delete();
            m_bcorr = 0;
            e1.bd = 1'b1;
        end
        e2.bl = m_bl; e2.bc = m_bc; e2.ts = m_ts; e2.tc = m_tc;
        last_e1 = e1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; clear_stats = 1'b0; in_valid = 1'b0; in_data = '0; in_label = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Drives n elements of sc[] (lb travels with element 0), random gaps up to
    // max_gap, then optionally captures the result cycle and the cycle after it.
    task automatic run_sample(input int n, input int max_gap, input bit want);
        bit r;
        @(posedge clk); #1;
        stalls = 0;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, max_gap)) begin
                in_valid = 1'b0; @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = sc[k];
            in_label = (k == 0) ? lb : 10'($urandom);
            for (int w = 0; w < 4; w++) begin
                @(negedge clk); r = in_ready;
                @(posedge clk); #1;
                if (r) break;
                if (k > 0) stalls++;
            end
        end
        in_valid = 1'b0;
        seen = 1'b0;
        if (want) begin
            for (int w = 0; w < 4 && !seen; w++) begin
                @(negedge clk);
                if (out_valid) begin
                    seen = 1'b1; lat = w; rdy_res = in_ready;
                    o1 = '{pc: pred_class, pcor: pred_correct, lerr: label_err, bd: batch_done};
                end
            end
            if (seen) begin
                @(negedge clk);
                ov_after = out_valid;
                o2 = '{bl: batch_loss, bc: batch_correct, ts: total_samples, tc: total_correct};
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; clear_stats = 1'b0; in_valid = 1'b0; in_data = '0; in_label = '0;
        #2;
        checks++;
        if ({out_valid, pred_class, pred_correct, label_err, batch_done, batch_loss,
             batch_correct, total_samples, total_correct} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b pc=%0d pcor=%b lerr=%b bd=%b bl=%h bc=%h ts=%h tc=%h expected all 0",
                     out_valid, pred_class, pred_correct, label_err, batch_done, batch_loss,
                     batch_correct, total_samples, total_correct);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        for (int k = 0; k < NC; k++) sc[k] = 16'(10 * (k + 1));
        lb = 10'(1 << 3);
        run_sample(NC, 0, 1); model_sample();
        checks++;
        if (!seen || lat != 0) begin
            errors++; $display("FAIL basic_latency: seen=%b extra_cycles=%0d expected seen=1 extra_cycles=0", seen, lat);
        end
        checks++;
        if (o1 !== e1) begin errors++; $display("FAIL basic_result: got %h expected %h", o1, e1); end
        checks++;
        if (o2 !== e2) begin errors++; $display("FAIL basic_stats: got %h expected %h", o2, e2); end
        checks++;
        if (ov_after !== 1'b0) begin errors++; $display("FAIL basic_pulse: out_valid after result got %b expected 0", ov_after); end
    endtask

    task automatic test_ties();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < NC; k++) sc[k] = (c == 0) ? 16'h0100 : 16'h0010;
            if (c == 1) sc[0] = 16'h0800;
            lb = (c == 0) ? 10'h001 : 10'h005;
            run_sample(NC, 0, 1); model_sample();
            checks++;
            if (!seen || o1 !== e1) begin errors++; $display("FAIL ties_result%0d: seen=%b got %h expected %h", c, seen, o1, e1); end
            checks++;
            if (o2 !== e2) begin errors++; $display("FAIL ties_stats%0d: got %h expected %h", c, o2, e2); end
        end
    endtask

    task automatic test_label_err();
        for (int k = 0; k < NC; k++) sc[k] = 16'($urandom);
        lb = '0;
        run_sample(NC, 1, 1); model_sample();
        checks++;
        if (!seen || o1 !== e1) begin errors++; $display("FAIL label_err_result: seen=%b got %h expected %h", seen, o1, e1); end
        checks++;
        if (o2 !== e2) begin errors++; $display("FAIL label_err_stats: got %h expected %h", o2, e2); end
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NC; k++) sc[k] = 16'(10 * (k + 1));
            lb = 10'(1 << 3);
            run_sample(NC, 3, 1); model_sample();
            checks++;
            if (!seen || o1 !== e1) begin errors++; $display("FAIL gaps_result%0d: seen=%b got %h expected %h", r, seen, o1, e1); end
            checks++;
            if (o2 !== e2) begin errors++; $display("FAIL gaps_stats%0d: got %h expected %h", r, o2, e2); end
            checks++;
            if (stalls != 0 || rdy_res !== 1'b0) begin
                errors++; $display("FAIL gaps_ready%0d: stalls=%0d ready_in_result=%b expected 0 and 0", r, stalls, rdy_res);
            end
        end
    endtask

    task automatic test_batch();
        apply_reset();
        for (int n = 0; n < 33; n++) begin
            for (int k = 0; k < NC; k++) sc[k] = '0;
            sc[n % NC] = 16'hFFFF;
            lb = 10'(1 << (n % NC));
            run_sample(NC, 0, 1); model_sample();
            checks++;
            if (!seen || o1 !== e1) begin errors++; $display("FAIL batch_result%0d: seen=%b got %h expected %h", n, seen, o1, e1); end
            checks++;
            if (o2 !== e2) begin errors++; $display("FAIL batch_stats%0d: got %h expected %h", n, o2, e2); end
            if (n == 31) begin
                checks++;
                if (o1.bd !== 1'b1 || o2.bc !== 16'd32 || o2.bl !== 32'd0) begin
                    errors++; $display("FAIL batch_end: bd=%b bc=%0d bl=%0d expected 1 32 0", o1.bd, o2.bc, o2.bl);
                end
            end
        end
    endtask

    task automatic test_random();
        int sel;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < NC; k++)
                sc[k] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 7));
            sel = $urandom_range(0, 5);
            lb  = (sel == 0) ? 10'h000 : (sel == 1) ? 10'($urandom) : 10'(1 << $urandom_range(0, NC - 1));
            run_sample(NC, 2, 1); model_sample();
            checks++;
            if (!seen || o1 !== e1) begin errors++; $display("FAIL random_result%0d: seen=%b got %h expected %h", n, seen, o1, e1); end
            checks++;
            if (o2 !== e2) begin errors++; $display("FAIL random_stats%0d: got %h expected %h", n, o2, e2); end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < NC; k++) sc[k] = 16'($urandom);
        lb = 10'(1 << $urandom_range(0, NC - 1));
        run_sample(5, 0, 0);
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({out_valid, pred_class, pred_correct, label_err, batch_done, batch_loss,
             batch_correct, total_samples, total_correct} !== '0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_outputs: ov=%b pc=%0d ts=%0d tc=%0d bl=%0d rdy=%b expected zeros and ready=1",
                               out_valid, pred_class, total_samples, total_correct, batch_loss, in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < NC; k++) sc[k] = 16'($urandom);
        run_sample(NC, 0, 1); model_sample();
        checks++;
        if (!seen || o1 !== e1) begin errors++; $display("FAIL reset_mid_fresh: seen=%b got %h expected %h", seen, o1, e1); end
        checks++;
        if (o2 !== e2) begin errors++; $display("FAIL reset_mid_stats: got %h expected %h", o2, e2); end
    endtask

    task automatic test_clear_mid();
        int ov_cnt;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < NC; k++) sc[k] = 16'($urandom);
            lb = 10'(1 << $urandom_range(0, NC - 1));
            run_sample(NC, 0, 1); model_sample();
        end
        for (int k = 0; k < NC; k++) sc[k] = 16'($urandom);
        run_sample(7, 0, 0);
        clear_stats = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL clear_ready: in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        clear_stats = 1'b0; in_valid = 1'b0;
        model_clear();
        ov_cnt = 0;
        repeat (4) begin @(negedge clk); if (out_valid) ov_cnt++; end
        checks++;
        if (ov_cnt != 0) begin errors++; $display("FAIL clear_no_result: out_valid pulses got %0d expected 0", ov_cnt); end
        checks++;
        if ({batch_loss, batch_correct, total_samples, total_correct} !== '0) begin
            errors++; $display("FAIL clear_stats: bl=%0d bc=%0d ts=%0d tc=%0d expected all 0",
                               batch_loss, batch_correct, total_samples, total_correct);
        end
        checks++;
        if ({pred_class, pred_correct, label_err} !== {last_e1.pc, last_e1.pcor, last_e1.lerr}) begin
            errors++; $display("FAIL clear_pred_hold: got %h expected %h", {pred_class, pred_correct, label_err},
                               {last_e1.pc, last_e1.pcor, last_e1.lerr});
        end
        for (int k = 0; k < NC; k++) sc[k] = 16'($urandom);
        lb = 10'(1 << $urandom_range(0, NC - 1));
        run_sample(NC, 1, 1); model_sample();
        checks++;
        if (!seen || o1 !== e1) begin errors++; $display("FAIL clear_next_result: seen=%b got %h expected %h", seen, o1, e1); end
        checks++;
        if (o2 !== e2) begin errors++; $display("FAIL clear_next_stats: got %h expected %h", o2, e2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_label_err();
        test_gaps();
        test_batch();
        test_random();
        test_reset_mid();
        test_clear_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_argmax_scorer.md
Name: fc_argmax_scorer

Overview:
- Sits directly downstream of fully_connected; consumes its NUM_CLASSES output scores as a serial stream, one score per cycle.
- Computes the predicted class (argmax) and the per-sample loss term against a one-hot label.
- Accumulates per-batch loss and correct-count, plus running totals, so accuracy reporting is done in hardware instead of in the bench.

Parameters:
- DATA_W, 16, score width; scores are unsigned.
- NUM_CLASSES, 10, scores per sample.
- CLASS_W, 4, width of the class index; must satisfy 2^CLASS_W >= NUM_CLASSES.
- BATCH_SIZE, 32, samples per batch.
- CNT_W, 16, width of the batch correct-count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear_stats  in  1  synchronous clear of all statistics and counters.
- in_valid  in  1  score element valid.
- in_ready  out  1  block can accept a score element.
- in_data  in  DATA_W  score element; index is implied by arrival order.
- in_label  in  NUM_CLASSES  one-hot true label; sampled with element 0 only.
- out_valid  out  1  one-cycle pulse: sample result valid.
- pred_class  out  CLASS_W  argmax index.
- pred_correct  out  1  pred_class equals the true class.
- label_err  out  1  latched label was all-zero.
- batch_done  out  1  one-cycle pulse: batch complete.
- batch_loss  out  32  loss sum of the last completed batch.
- batch_correct  out  CNT_W  correct count of the last completed batch.
- total_samples  out  32  samples scored since reset or clear.
- total_correct  out  32  correct samples since reset or clear.

Behaviour:
- Reset (reset=0, asynchronous): every output and internal register goes to 0, except in_ready=1. State goes to IDLE.
- States:
  - IDLE: waiting for element 0.
  - ACCUM: elements 1..NUM_CLASSES-1 pending.
  - RESULT: one cycle, in_ready=0.
- Accept rule: an element is accepted only when in_valid && in_ready. Gaps in in_valid stall the element counter and leave results unchanged.
- IDLE, on accept:
  - latch in_label, best=in_data, best_idx=0.
  - start the loss term if label bit 0 is set.
  - element counter to 1, go to ACCUM (or to RESULT if NUM_CLASSES=1).
- ACCUM, on accepting element k:
  - if in_data > best (unsigned, strictly greater), update best and best_idx=k. Ties keep the lowest index.
  - if k is the true class, loss term = 0xFFFF - in_data, zero-extended to 32 bits.
  - after k = NUM_CLASSES-1, go to RESULT.
- True class is the lowest set bit of the latched label.
- All-zero label: label_err=1, loss term 0, pred_correct=0; the sample still counts toward totals.
- Multi-hot labels are not an error; the lowest set bit wins.
- RESULT (one cycle):
  - out_valid=1; pred_class, pred_correct and label_err are driven and held until the next out_valid.
  - total_samples increments; total_correct increments if the sample is correct.
  - batch sample counter increments; the loss accumulator and correct accumulator update.
  - Loss accumulator saturates at 0xFFFFFFFF.
  - Next cycle returns to IDLE with in_ready=1. Latency is 1 cycle after the last element; throughput is NUM_CLASSES+1 cycles per sample at full rate.
- Batch completion: in the RESULT cycle of sample BATCH_SIZE, batch_done=1 in the same cycle as out_valid.
  - batch_loss and batch_correct are loaded with the accumulated values, including this sample, and held until the next batch_done.
  - Internal accumulators and the batch counter clear to 0.
- Totals wrap modulo 2^32; no saturation.
- clear_stats=1 (synchronous, highest priority):
  - aborts any in-progress sample and goes to IDLE.
  - an element presented in that cycle is dropped; in_ready=0 while clear_stats=1.
  - clears totals, accumulators, counters, batch_loss and batch_correct.
  - out_valid and batch_done are forced to 0 that cycle.
  - pred_class, pred_correct and label_err keep their last value.
- Asynchronous reset mid-sample discards the partial sample; no out_valid is produced for it.

Test Plan:
1. Scores 10,20,...,100 (element k = 10*(k+1)), label=1<<3 -> out_valid 1 cycle after element 9; pred_class=9, pred_correct=0, loss term 65495, total_samples=1, total_correct=0.
2. All scores 0x0100, label=1<<0 -> pred_class=0 (tie picks the lowest index), pred_correct=1. Label 0x005 with scores peaking at index 0 -> true class 0, correct=1.
3. 32 samples, each with a peak of 0xFFFF at index (n mod 10) and all other scores 0, label=1<<(n mod 10) -> batch_done coincides with the 32nd out_valid; batch_correct=32, batch_loss=0. Sample 33 gives no batch_done; batch_loss holds 0.
4. Same as scenario 1 but with random 0–3 cycle in_valid gaps -> identical results; in_ready=0 only in the RESULT cycle; no element is lost.
5. label=0, any scores -> label_err=1, pred_correct=0, loss term 0, total_samples increments.
6. Two cases:
   - reset=0 pulsed after element 4 -> all outputs 0 immediately; the next 10 elements form a fresh sample.
   - clear_stats pulsed after element 6 of sample 5 -> totals=0, no out_valid for the aborted sample; the next sample scores correctly.
